pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000: PC loaded after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100: PC loaded on a misaligned redirect.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc  input  32  current PC from PC register.
REQ-006 SHALL have port pc_add4  input  32  sequential next PC from pc_adder.
REQ-007 SHALL have port pc_imm  input  32  branch/JAL target from pc_adder.
REQ-008 SHALL have port br_taken  input  1  branch/JAL taken, one-cycle pulse.
REQ-009 SHALL have port jalr  input  1  JALR taken, one-cycle pulse.
REQ-010 SHALL have port jalr_target  input  32  rs1+imm for JALR.
REQ-011 SHALL have port stall  input  1  decode backpressure, level.
REQ-012 SHALL have port imem_ack  input  1  instruction memory fetch complete.
REQ-013 SHALL have port pc_en  output  1  PC register load enable.
REQ-014 SHALL have port pc_tmp  output  32  next PC to PC register.
REQ-015 SHALL have port imem_req  output  1  fetch request at address pc.
REQ-016 SHALL have port if_valid  output  1  fetched instruction valid for decode.
REQ-017 SHALL have port misalign  output  1  misaligned-target pulse.

Function
REQ-018 SHALL implement FSM states BOOT, REQ, WAIT, HOLD.
REQ-019 BOOT: pc_en=1, pc_tmp=RESET_VEC for exactly one cycle; redirects ignored; next state REQ.
REQ-020 REQ: imem_req=1; without ack, next state WAIT. WAIT: imem_req=1 until imem_ack. imem_ack SHALL be ignored while imem_req=0.
REQ-021 On ack, no redirect pending or present, stall=0: if_valid=1, pc_en=1, pc_tmp=pc_add4; next state REQ.
REQ-022 On ack, no redirect, stall=1: if_valid=1, pc_en=0; next state HOLD.
REQ-023 HOLD: if_valid held at 1, pc_en=0 while stall=1; on stall=0, pc_en=1, pc_tmp=pc_add4; next state REQ.
REQ-024 Redirect target: jalr has priority over br_taken; JALR target = jalr_target with bit0 cleared; branch target = pc_imm.
REQ-025 Redirect in REQ/WAIT without ack: captured into pending register; a later redirect before ack overwrites it.
REQ-026 Ack with pending or same-cycle redirect: if_valid=0 (instruction discarded), pc_en=1, pc_tmp=redirect target (same-cycle over pending); pending cleared; next state REQ.
REQ-027 Redirect in HOLD: applied in that cycle regardless of stall; if_valid=0, pc_en=1; next state REQ.
REQ-028 Applied target with bits[1:0]!=0: pc_tmp=TRAP_VEC, misalign=1 for that cycle only.
REQ-029 pc_en SHALL be 1 for at most one cycle per PC update and never in WAIT without ack.
REQ-030 No arithmetic on PC values beyond bit0 clearing; wrap-around of pc_add4 is passed through unchanged.

Reset
REQ-031 While rst=0: pc_en=0, pc_tmp=RESET_VEC, imem_req=0, if_valid=0, misalign=0, pending cleared, state BOOT.
REQ-032 Reset asserted mid-fetch SHALL abandon the fetch immediately (imem_req drops asynchronously); a late ack after release SHALL be ignored until REQ.

Structure
REQ-033 Package pc_ctrl_pkg SHALL hold the FSM state enum and RESET_VEC/TRAP_VEC default constants.
REQ-034 Pending-redirect capture (valid flag + 32-bit target, priority merge) SHALL be sub-module pc_redirect_reg.
REQ-035 Controller SHALL drive PC.en and PC.pc_tmp directly; pc_adder remains unchanged.

Verification
REQ-036 Release rst, ack every REQ in one cycle -> pc_en pulse with pc_tmp=0x0, then if_valid with PC sequence 0x0,0x4,0x8,0xC.
REQ-037 br_taken=1, pc_imm=0x40 during WAIT, ack 3 cycles later -> if_valid=0 on ack, pc_tmp=0x40, next fetch at 0x40.
REQ-038 jalr=1, jalr_target=0x81 and br_taken=1, pc_imm=0x20 same cycle -> pc_tmp=0x80.
REQ-039 jalr_target=0x62 applied -> pc_tmp=0x100, misalign pulse exactly one cycle.
REQ-040 stall=1 at ack for 4 cycles -> if_valid held 4 cycles, pc_en=0; stall drop -> pc_en=1, pc_tmp=pc+4.
REQ-041 rst low during WAIT with pc=0x24, ack after release -> imem_req=0 during reset, ack ignored, restart at 0x0.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the fetch-side PC controller.
//   - pc_state_e     : controller FSM states
//   - RESET_VEC_DEF  : default PC loaded after reset
//   - TRAP_VEC_DEF   : default PC loaded on a misaligned redirect
//   - jalr_align()   : clears bit 0 of a JALR target
//   - is_misaligned(): flags a target whose low two bits are non-zero
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } pc_state_e;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;

  function automatic logic [31:0] jalr_align(input logic [31:0] target);
    return target & 32'hFFFF_FFFE;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_reg.sv
// pc_redirect_reg: holds a redirect that arrived while a fetch was still
// outstanding and merges it with any redirect presented in the current cycle.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   jalr, br_taken  : redirect pulses (jalr wins)
//   jalr_target     : JALR target (bit 0 cleared here)
//   pc_imm          : branch/JAL target
//   capture         : store a current-cycle redirect into the pending slot
//   clear           : drop the pending redirect (has priority over capture)
//   redir_now       : a redirect is presented this cycle
//   redir_any       : a redirect is presented this cycle or is pending
//   redir_tgt       : merged target, current-cycle redirect over pending one
module pc_redirect_reg
  import pc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        jalr,
  input  logic        br_taken,
  input  logic [31:0] jalr_target,
  input  logic [31:0] pc_imm,
  input  logic        capture,
  input  logic        clear,
  output logic        redir_now,
  output logic        redir_any,
  output logic [31:0] redir_tgt
);

  logic        pend_valid;
  logic [31:0] pend_tgt;
  logic [31:0] now_tgt;

  // Current-cycle target selection and merge with the pending slot.
  always_comb begin
    redir_now = jalr | br_taken;
    now_tgt   = jalr ? jalr_align(jalr_target) : pc_imm;
    redir_any = redir_now | pend_valid;
    if (redir_now) begin
      redir_tgt = now_tgt;
    end else begin
      redir_tgt = pend_tgt;
    end
  end

  // Pending slot: a later capture simply overwrites an earlier one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_tgt   <= 32'h0000_0000;
    end else if (clear) begin
      pend_valid <= 1'b0;
      pend_tgt   <= 32'h0000_0000;
    end else if (capture && redir_now) begin
      pend_valid <= 1'b1;
      pend_tgt   <= now_tgt;
    end else begin
      pend_valid <= pend_valid;
      pend_tgt   <= pend_tgt;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-side PC controller. Sequences instruction fetches, hands
// fetched instructions to decode, and steers the PC register on sequential
// advance, branch/JAL, JALR and misaligned-target traps.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   pc           : current PC register value
//   pc_add4      : sequential next PC
//   pc_imm       : branch/JAL target
//   br_taken     : branch/JAL taken pulse
//   jalr         : JALR taken pulse
//   jalr_target  : rs1+imm for JALR
//   stall        : decode backpressure (level)
//   imem_ack     : fetch complete
//   pc_en        : PC register load enable
//   pc_tmp       : value for the PC register
//   imem_req     : fetch request at address pc
//   if_valid     : fetched instruction valid for decode
//   misalign     : misaligned redirect target trapped this cycle
// Outputs are decoded from state and inputs in the same cycle because the
// ack/redirect responses must land in the cycle they occur; all outputs are
// forced to their reset values combinationally while rst is low so an
// outstanding request drops without waiting for a clock.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pc_add4,
  input  logic [31:0] pc_imm,
  input  logic        br_taken,
  input  logic        jalr,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  input  logic        imem_ack,
  output logic        pc_en,
  output logic [31:0] pc_tmp,
  output logic        imem_req,
  output logic        if_valid,
  output logic        misalign
);

  pc_state_e   state;
  pc_state_e   state_nxt;
  logic        capture;
  logic        clear;
  logic        apply;
  logic        redir_now;
  logic        redir_any;
  logic [31:0] redir_tgt;

  pc_redirect_reg u_redirect (
    .clk         (clk),
    .rst         (rst),
    .jalr        (jalr),
    .br_taken    (br_taken),
    .jalr_target (jalr_target),
    .pc_imm      (pc_imm),
    .capture     (capture),
    .clear       (clear),
    .redir_now   (redir_now),
    .redir_any   (redir_any),
    .redir_tgt   (redir_tgt)
  );

  // Output decode and next-state logic.
  always_comb begin
    pc_en     = 1'b0;
    pc_tmp    = pc;
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    misalign  = 1'b0;
    capture   = 1'b0;
    clear     = 1'b0;
    apply     = 1'b0;
    state_nxt = state;

    if (!rst) begin
      pc_tmp    = RESET_VEC;
      state_nxt = ST_BOOT;
    end else begin
      case (state)
        ST_BOOT: begin
          // Redirects are not captured here: the boot load always wins.
          pc_en     = 1'b1;
          pc_tmp    = RESET_VEC;
          state_nxt = ST_REQ;
        end
        ST_REQ, ST_WAIT: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            clear     = 1'b1;
            state_nxt = ST_REQ;
            if (redir_any) begin
              // Fetched instruction is on the wrong path: drop it.
              apply = 1'b1;
            end else if (!stall) begin
              if_valid = 1'b1;
              pc_en    = 1'b1;
              pc_tmp   = pc_add4;
            end else begin
              if_valid  = 1'b1;
              state_nxt = ST_HOLD;
            end
          end else begin
            capture   = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (redir_now) begin
            apply     = 1'b1;
            state_nxt = ST_REQ;
          end else if (!stall) begin
            if_valid  = 1'b1;
            pc_en     = 1'b1;
            pc_tmp    = pc_add4;
            state_nxt = ST_REQ;
          end else begin
            if_valid  = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
        default: begin
          state_nxt = ST_BOOT;
        end
      endcase

      // Redirect load; a target that is not word aligned traps instead.
      if (apply) begin
        pc_en = 1'b1;
        if (is_misaligned(redir_tgt[1:0])) begin
          pc_tmp   = TRAP_VEC;
          misalign = 1'b1;
        end else begin
          pc_tmp = redir_tgt;
        end
      end else begin
        misalign = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: randomized self-checking bench for pc_ctrl. A behavioural
// model tracks whether the controller is booting, fetching or holding an
// instruction, plus a one-deep "last redirect wins" pending slot, and
// predicts every output each cycle. The bench also plays the PC register.
module tb_pc_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_add4 = 32'h4;
  logic [31:0] pc_imm = 32'h0;
  logic        br_taken = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] jalr_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic        pc_en;
  logic [31:0] pc_tmp;
  logic        imem_req;
  logic        if_valid;
  logic        misalign;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_add4     (pc_add4),
    .pc_imm      (pc_imm),
    .br_taken    (br_taken),
    .jalr        (jalr),
    .jalr_target (jalr_target),
    .stall       (stall),
    .imem_ack    (imem_ack),
    .pc_en       (pc_en),
    .pc_tmp      (pc_tmp),
    .imem_req    (imem_req),
    .if_valid    (if_valid),
    .misalign    (misalign)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Model state.
  bit          m_boot = 1'b1;
  bit          m_hold = 1'b0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_t = 32'h0;
  logic [31:0] pc_reg = 32'h0;

  // Model predictions for the current cycle.
  logic        e_en, e_req, e_valid, e_mis;
  logic [31:0] e_tmp;

  function automatic logic [31:0] target_now();
    if (jalr) return jalr_target - (jalr_target % 32'd2);
    return pc_imm;
  endfunction

  task automatic load_target(input logic [31:0] t);
    e_en = 1'b1;
    if ((t % 32'd4) != 32'd0) begin
      e_tmp = TV;
      e_mis = 1'b1;
    end else begin
      e_tmp = t;
    end
  endtask

  task automatic model_outputs();
    bit redir;
    redir   = jalr || br_taken;
    e_en    = 1'b0;
    e_req   = 1'b0;
    e_valid = 1'b0;
    e_mis   = 1'b0;
    e_tmp   = 32'h0;
    if (!rst) begin
      e_tmp = RV;
    end else if (m_boot) begin
      e_en  = 1'b1;
      e_tmp = RV;
    end else if (m_hold) begin
      if (redir) load_target(target_now());
      else begin
        e_valid = 1'b1;
        e_en    = !stall;
        e_tmp   = pc_reg + 32'd4;
      end
    end else begin
      e_req = 1'b1;
      if (imem_ack) begin
        if (redir) load_target(target_now());
        else if (m_pend) load_target(m_pend_t);
        else begin
          e_valid = 1'b1;
          e_en    = !stall;
          e_tmp   = pc_reg + 32'd4;
        end
      end
    end
  endtask

  task automatic model_step();
    bit redir;
    redir = jalr || br_taken;
    if (!rst) begin
      m_boot = 1'b1;
      m_hold = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (e_en) pc_reg = e_tmp;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_hold) begin
        if (redir || !stall) m_hold = 1'b0;
      end else if (imem_ack) begin
        if (!redir && !m_pend && stall) m_hold = 1'b1;
        m_pend = 1'b0;
      end else if (redir) begin
        m_pend   = 1'b1;
        m_pend_t = target_now();
      end
    end
  endtask

  initial begin
    int rst_cnt;
    rst_cnt = 3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst_cnt > 0) begin
        rst = 1'b0;
        rst_cnt--;
      end else begin
        rst = 1'b1;
        if (cyc > 40 && $urandom_range(0, 99) == 0) begin
          rst     = 1'b0;
          rst_cnt = 1;
        end
      end
      pc      = pc_reg;
      pc_add4 = pc_reg + 32'd4;
      if (cyc < 16) begin
        // Clean sequential start: every request acked at once.
        imem_ack = 1'b1;
        stall    = 1'b0;
        br_taken = 1'b0;
        jalr     = 1'b0;
      end else begin
        imem_ack = ($urandom_range(0, 9) < 4);
        stall    = ($urandom_range(0, 2) == 0);
        br_taken = ($urandom_range(0, 7) == 0);
        jalr     = ($urandom_range(0, 9) == 0);
      end
      jalr_target = 32'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0:       pc_imm = 32'hFFFF_FFFC;
        1:       pc_imm = ($urandom & 32'hFFFF_FFFC) | 32'h2;
        default: pc_imm = $urandom & 32'hFFFF_FFFC;
      endcase
      #1;
      model_outputs();
      chk("pc_en", {31'h0, pc_en}, {31'h0, e_en});
      chk("imem_req", {31'h0, imem_req}, {31'h0, e_req});
      chk("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
      chk("misalign", {31'h0, misalign}, {31'h0, e_mis});
      if (!rst || e_en) chk("pc_tmp", pc_tmp, e_tmp);
      @(posedge clk);
      model_step();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
